// File: rtl/video_tpg_pkg.sv
// video_tpg_pkg
//   Shared definitions for the video test-pattern generator:
//   - default 640x480@60 timing constants
//   - test-pattern mode codes (MODE_RED..MODE_BAR)
//   - RGB888 colour constants and the colour-bar lookup helper
package video_tpg_pkg;

    // Default 640x480@60 raster (25 MHz pixel clock).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Raster counter width (covers up to 1023 pixels/lines).
    localparam int unsigned CNT_W = 10;

    typedef logic [3:0]  mode_t;
    typedef logic [23:0] rgb_t;

    localparam mode_t MODE_RED       = 4'd1;
    localparam mode_t MODE_GREEN     = 4'd2;
    localparam mode_t MODE_BLUE      = 4'd3;
    localparam mode_t MODE_WHITE     = 4'd4;
    localparam mode_t MODE_BLACK     = 4'd5;
    localparam mode_t MODE_BARS      = 4'd6;
    localparam mode_t MODE_GREY_RAMP = 4'd7;
    localparam mode_t MODE_CHECKER   = 4'd8;
    localparam mode_t MODE_RED_RAMP  = 4'd9;
    localparam mode_t MODE_BORDER    = 4'd10;
    localparam mode_t MODE_BAR       = 4'd11;

    localparam rgb_t COL_WHITE   = 24'hFFFFFF;
    localparam rgb_t COL_YELLOW  = 24'hFFFF00;
    localparam rgb_t COL_CYAN    = 24'h00FFFF;
    localparam rgb_t COL_GREEN   = 24'h00FF00;
    localparam rgb_t COL_MAGENTA = 24'hFF00FF;
    localparam rgb_t COL_RED     = 24'hFF0000;
    localparam rgb_t COL_BLUE    = 24'h0000FF;
    localparam rgb_t COL_BLACK   = 24'h000000;

    // Colour of vertical bar 'idx' (0 = leftmost) in the eight-bar pattern.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = COL_WHITE;
            3'd1:    bar_colour = COL_YELLOW;
            3'd2:    bar_colour = COL_CYAN;
            3'd3:    bar_colour = COL_GREEN;
            3'd4:    bar_colour = COL_MAGENTA;
            3'd5:    bar_colour = COL_RED;
            3'd6:    bar_colour = COL_BLUE;
            default: bar_colour = COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Horizontal/vertical raster counters with combinational decode of
//   sync, active-video and frame-start. Decoded outputs are unregistered;
//   the parent registers them together with the pixel data.
// Ports:
//   clk_i    pixel clock
//   rst_i    asynchronous active-high reset
//   h_cnt_o  current pixel index within the line
//   v_cnt_o  current line index within the frame
//   hs_o     horizontal sync (level per HS_POL)
//   vs_o     vertical sync (level per VS_POL)
//   de_o     active-video region
//   fs_o     frame start (h_cnt = 0 and v_cnt = 0)
module video_timing_gen
    import video_tpg_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             de_o,
    output logic             fs_o
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] HA       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA       = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o = h_q;
    assign v_cnt_o = v_q;
    assign de_o    = (h_q < HA) && (v_q < VA);
    // VS depends only on v_q, which changes on the h wrap, so its edges
    // land on h_cnt = 0.
    assign hs_o    = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    assign vs_o    = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    assign fs_o    = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/video_tpg.sv
// video_tpg
//   640x480@60 video timing and RGB888 test-pattern generator.
//   The pattern mode is captured once per frame (at frame start) so a
//   frame is never rendered with two different patterns.
//   Optional feature macro: TPG_MOVING_BAR_EN enables the moving-bar
//   pattern (mode 11); without it mode 11 renders black and no bar
//   position state exists.
// Ports:
//   PXLCLK_I    pixel clock
//   RST_I       asynchronous active-high reset
//   DEN_I       pattern enable; low blanks RGB, timing unaffected
//   TPG_MODE_I  pattern select
//   HS_O/VS_O   horizontal/vertical sync
//   DE_O        active-video enable
//   FS_O        one-cycle frame-start pulse
//   R_O/G_O/B_O pixel colour
//   All outputs are registered and mutually aligned.
module video_tpg
    import video_tpg_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned BAR_W    = 64,
    parameter int unsigned BAR_STEP = 4
) (
    input  logic       PXLCLK_I,
    input  logic       RST_I,
    input  logic       DEN_I,
    input  logic [3:0] TPG_MODE_I,
    output logic       HS_O,
    output logic       VS_O,
    output logic       DE_O,
    output logic       FS_O,
    output logic [7:0] R_O,
    output logic [7:0] G_O,
    output logic [7:0] B_O
);

    localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HA_M1  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VA_M1  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR8_W = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             hs_c, vs_c, de_c, fs_c;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (HS_POL),   .VS_POL (VS_POL)
    ) u_timing (
        .clk_i   (PXLCLK_I),
        .rst_i   (RST_I),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt),
        .hs_o    (hs_c),
        .vs_o    (vs_c),
        .de_o    (de_c),
        .fs_o    (fs_c)
    );

    // On the frame-start cycle the freshly sampled mode already applies to
    // pixel (0,0), so the new pattern begins at the very first pixel.
    mode_t mode_q;
    mode_t mode_eff;
    assign mode_eff = fs_c ? TPG_MODE_I : mode_q;

    always_ff @(posedge PXLCLK_I or posedge RST_I) begin
        if (RST_I)     mode_q <= '0;
        else if (fs_c) mode_q <= TPG_MODE_I;
    end

`ifdef TPG_MOVING_BAR_EN
    localparam logic [CNT_W-1:0] STEP = CNT_W'(BAR_STEP);
    localparam logic [CNT_W-1:0] BW   = CNT_W'(BAR_W);

    // bar_pos_q advances at every frame start; bar_frame_q holds the
    // position rendered during the current frame (the pre-advance value).
    logic [CNT_W-1:0] bar_pos_q, bar_pos_d;
    logic [CNT_W-1:0] bar_frame_q;
    logic [CNT_W-1:0] bar_eff, bar_diff;
    logic [CNT_W:0]   bar_sum;
    logic             in_bar;

    always_comb begin
        bar_sum   = {1'b0, bar_pos_q} + {1'b0, STEP};
        bar_pos_d = (bar_sum >= {1'b0, HA}) ? CNT_W'(bar_sum - {1'b0, HA})
                                            : bar_sum[CNT_W-1:0];
        bar_eff   = fs_c ? bar_pos_q : bar_frame_q;
        // (h - pos) mod H_ACTIVE; the 10-bit wrap of h + HA - pos is
        // harmless because the true result is below H_ACTIVE.
        bar_diff  = (h_cnt >= bar_eff) ? h_cnt - bar_eff : h_cnt + HA - bar_eff;
        in_bar    = bar_diff < BW;
    end

    always_ff @(posedge PXLCLK_I or posedge RST_I) begin
        if (RST_I) begin
            bar_pos_q   <= '0;
            bar_frame_q <= '0;
        end else if (fs_c) begin
            bar_pos_q   <= bar_pos_d;
            bar_frame_q <= bar_pos_q;
        end
    end
`endif

    logic [2:0] bars_idx;
    rgb_t       rgb_d, rgb_q;

    assign bars_idx = 3'(h_cnt / BAR8_W);

    always_comb begin
        rgb_d = COL_BLACK;
        if (DEN_I && de_c) begin
            case (mode_eff)
                MODE_RED:       rgb_d = COL_RED;
                MODE_GREEN:     rgb_d = COL_GREEN;
                MODE_BLUE:      rgb_d = COL_BLUE;
                MODE_WHITE:     rgb_d = COL_WHITE;
                MODE_BARS:      rgb_d = bar_colour(bars_idx);
                MODE_GREY_RAMP: rgb_d = {3{h_cnt[7:0]}};
                MODE_CHECKER:   rgb_d = (h_cnt[5] ^ v_cnt[5]) ? COL_WHITE : COL_BLACK;
                MODE_RED_RAMP:  rgb_d = {v_cnt[7:0], 16'h0000};
                MODE_BORDER:    rgb_d = ((h_cnt == '0) || (h_cnt == HA_M1) ||
                                         (v_cnt == '0) || (v_cnt == VA_M1)) ? COL_WHITE : COL_BLACK;
`ifdef TPG_MOVING_BAR_EN
                MODE_BAR:       rgb_d = in_bar ? COL_WHITE : COL_BLACK;
`endif
                default:        rgb_d = COL_BLACK;
            endcase
        end
    end

    logic hs_q, vs_q, de_q, fs_q;

    always_ff @(posedge PXLCLK_I or posedge RST_I) begin
        if (RST_I) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            rgb_q <= COL_BLACK;
        end else begin
            hs_q  <= hs_c;
            vs_q  <= vs_c;
            de_q  <= de_c;
            fs_q  <= fs_c;
            rgb_q <= rgb_d;
        end
    end

    assign HS_O = hs_q;
    assign VS_O = vs_q;
    assign DE_O = de_q;
    assign FS_O = fs_q;
    assign R_O  = rgb_q[23:16];
    assign G_O  = rgb_q[15:8];
    assign B_O  = rgb_q[7:0];

endmodule

// File: tb/tb_video_tpg.sv
// Testbench for video_tpg using a reduced raster (64x34 active) so that
// many frames fit in a short run. An expectation process pushes the
// required output word each clock; a monitor pops and compares on the
// opposite edge.
module tb_video_tpg;

    localparam int HA = 64, HFP = 2, HSY = 4, HBP = 2;
    localparam int VA = 34, VFP = 1, VSY = 2, VBP = 1;
    localparam int BW = 24, BSTEP = 16;
    localparam int HT = HA + HFP + HSY + HBP;   // 72
    localparam int VT = VA + VFP + VSY + VBP;   // 38
    localparam int FRAME = HT * VT;             // 2736

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       den = 1'b1;
    logic [3:0] mode = 4'd4;
    logic       hs, vs, de, fs;
    logic [7:0] r, g, b;

    int total = 0;
    int bad   = 0;
    logic [27:0] expq[$];
    localparam logic [27:0] RST_WORD = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

    always #5 clk = ~clk;

    video_tpg #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .HS_POL   (1'b0), .VS_POL (1'b0),
        .BAR_W    (BW), .BAR_STEP (BSTEP)
    ) dut (
        .PXLCLK_I   (clk),
        .RST_I      (rst),
        .DEN_I      (den),
        .TPG_MODE_I (mode),
        .HS_O       (hs),
        .VS_O       (vs),
        .DE_O       (de),
        .FS_O       (fs),
        .R_O        (r),
        .G_O        (g),
        .B_O        (b)
    );

    // Hand-written pattern table.
    function automatic logic [23:0] exp_pix(int m, int h, int v, int bar);
        logic [7:0] lv;
        exp_pix = 24'h000000;
        case (m)
            1:  exp_pix = 24'hFF0000;
            2:  exp_pix = 24'h00FF00;
            3:  exp_pix = 24'h0000FF;
            4:  exp_pix = 24'hFFFFFF;
            6: begin
                case (h / (HA / 8))
                    0: exp_pix = 24'hFFFFFF;
                    1: exp_pix = 24'hFFFF00;
                    2: exp_pix = 24'h00FFFF;
                    3: exp_pix = 24'h00FF00;
                    4: exp_pix = 24'hFF00FF;
                    5: exp_pix = 24'hFF0000;
                    6: exp_pix = 24'h0000FF;
                    default: exp_pix = 24'h000000;
                endcase
            end
            7: begin
                lv = 8'(h);
                exp_pix = {lv, lv, lv};
            end
            8:  if (((h / 32) % 2) != ((v / 32) % 2)) exp_pix = 24'hFFFFFF;
            9: begin
                lv = 8'(v);
                exp_pix = {lv, 16'h0000};
            end
            10: if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) exp_pix = 24'hFFFFFF;
            11: begin
`ifdef TPG_MOVING_BAR_EN
                int d;
                d = (((h - bar) % HA) + HA) % HA;
                if (d < BW) exp_pix = 24'hFFFFFF;
`endif
            end
            default: exp_pix = 24'h000000;
        endcase
    endfunction

    // Expectation generator: tracks the raster and pushes the word the DUT
    // must present after each rising edge.
    int mh = 0, mv = 0, mmode = 0, mbar_next = 0, mbar_cur = 0;
    logic e_hs, e_vs, e_de, e_fs;
    logic [23:0] e_rgb;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                expq.push_back(RST_WORD);
                mh = 0; mv = 0; mmode = 0; mbar_next = 0; mbar_cur = 0;
            end else begin
                e_fs = (mh == 0 && mv == 0);
                if (e_fs) begin
                    mmode     = int'(mode);
                    mbar_cur  = mbar_next;
                    mbar_next = (mbar_next + BSTEP) % HA;
                end
                e_de  = (mh < HA) && (mv < VA);
                e_hs  = !(mh >= HA + HFP && mh < HA + HFP + HSY);
                e_vs  = !(mv >= VA + VFP && mv < VA + VFP + VSY);
                e_rgb = (e_de && den) ? exp_pix(mmode, mh, mv, mbar_cur) : 24'h000000;
                expq.push_back({e_hs, e_vs, e_de, e_fs, e_rgb});
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv++;
                    if (mv == VT) mv = 0;
                end
            end
        end
    end

    // Monitor: compares every output word plus run-length measurements.
    int cyc = 0, last_fs = -1, de_run = 0, hs_run = 0;
    logic de_prev = 1'b0, hs_prev = 1'b1;
    logic [27:0] got, expw;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            got = {hs, vs, de, fs, r, g, b};
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL queue_empty cyc=%0d got=%h required=queued entry", cyc, got);
            end else begin
                expw = expq.pop_front();
                if (got !== expw) begin
                    bad++;
                    $display("FAIL out cyc=%0d got=%h required=%h", cyc, got, expw);
                end
            end
            if (rst) begin
                last_fs = -1; de_run = 0; de_prev = 1'b0; hs_run = 0; hs_prev = 1'b1;
            end else begin
                if (fs === 1'b1) begin
                    if (last_fs >= 0) begin
                        total++;
                        if (cyc - last_fs != FRAME) begin
                            bad++;
                            $display("FAIL frame_period got=%0d required=%0d", cyc - last_fs, FRAME);
                        end
                    end
                    last_fs = cyc;
                end
                if (de === 1'b1) de_run++;
                else if (de_prev) begin
                    total++;
                    if (de_run != HA) begin
                        bad++;
                        $display("FAIL de_run got=%0d required=%0d", de_run, HA);
                    end
                    de_run = 0;
                end
                de_prev = de;
                if (hs === 1'b0) hs_run++;
                else if (!hs_prev) begin
                    total++;
                    if (hs_run != HSY) begin
                        bad++;
                        $display("FAIL hs_low_run got=%0d required=%0d", hs_run, HSY);
                    end
                    hs_run = 0;
                end
                hs_prev = hs;
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int mode_list[7] = '{7, 8, 9, 10, 0, 3, 12};

    initial begin
        run(3);
        rst = 1'b0;
        run(FRAME / 2);              // all later changes land mid-frame
        run(2 * FRAME);              // mode 4 white
        mode = 4'd6;  run(FRAME);    // colour bars
        mode = 4'd1;  run(FRAME);    // red frame
        mode = 4'd2;  run(FRAME);    // switched mid red frame; next is green
        mode = 4'd4;  den = 1'b0; run(FRAME);
        den = 1'b1;
        foreach (mode_list[i]) begin
            mode = 4'(mode_list[i]);
            run(FRAME);
        end
        mode = 4'd11; run(5 * FRAME); // bar at 0,16,32,48(wrap),0
        mode = 4'd4;  run(FRAME / 3 + 5);
        // Mid-line reset: outputs must drop to reset values at once.
        rst = 1'b1;
        #1;
        total++;
        if ({hs, vs, de, fs, r, g, b} !== RST_WORD) begin
            bad++;
            $display("FAIL async_reset got=%h required=%h", {hs, vs, de, fs, r, g, b}, RST_WORD);
        end
        run(3);
        rst = 1'b0;
        run(FRAME + HT);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        bad++;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_tpg.md
# video_tpg

Pixel-domain video timing and test-pattern generator feeding the HDMI/TMDS transmit stage. Produces 640x480@60 raster timing (HS, VS, DE) and RGB888 pixel data for eleven selectable test patterns. The pattern mode is sampled once per frame so the downstream encoder never sees a mid-frame pattern change.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, HS active level
- VS_POL, 0, VS active level
- BAR_W, 64, moving-bar width in pixels
- BAR_STEP, 4, moving-bar advance per frame in pixels

Ports:
- PXLCLK_I  input  1  pixel clock (25 MHz)
- RST_I  input  1  reset; one clock, asynchronous, active-high
- DEN_I  input  1  pattern enable; low forces RGB to 0 while timing continues
- TPG_MODE_I  input  4  pattern select
- HS_O  output  1  horizontal sync
- VS_O  output  1  vertical sync
- DE_O  output  1  active-video enable
- FS_O  output  1  one-cycle frame-start pulse
- R_O / G_O / B_O  output  8 each  pixel colour

## Operation
- Counters: h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params, 800). v_cnt increments when h_cnt wraps, counting 0..V_TOTAL-1 (525). Both wrap to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- HS asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- VS asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491. VS edges coincide with h_cnt=0.
- Frame start: h_cnt=0 and v_cnt=0. On this cycle:
  - mode_q <= TPG_MODE_I.
  - bar_pos advances.
  - FS_O pulses.
- Patterns, selected by mode_q and evaluated on active pixels only:
  - 1 red FF0000
  - 2 green 00FF00
  - 3 blue 0000FF
  - 4 white
  - 5 black
  - 6 eight vertical bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black
  - 7 grey ramp, R=G=B=h_cnt[7:0]
  - 8 checkerboard, white when h_cnt[5]^v_cnt[5], else black
  - 9 red ramp, R=v_cnt[7:0], G=B=0
  - 10 white 1-pixel border (h_cnt 0 or H_ACTIVE-1, v_cnt 0 or V_ACTIVE-1) on black
  - 11 moving bar (see Configuration)
  - 0 and 12..15 black
- Outside the active region, and whenever DEN_I=0, RGB = 0.
- Arithmetic:
  - h_cnt and v_cnt are 10 bits wide, unsigned.
  - Bar test is ((h_cnt - bar_pos) mod H_ACTIVE) < BAR_W, with correct wrap.
  - bar_pos update is (bar_pos + BAR_STEP) mod H_ACTIVE.

## Timing
- Reset values: h_cnt=v_cnt=0, mode_q=0, bar_pos=0, HS_O=~HS_POL, VS_O=~VS_POL, DE_O=0, FS_O=0, RGB=0.
- All outputs are registered. HS_O, VS_O, DE_O, FS_O and RGB are mutually aligned, one cycle after the counter values they reflect.
- The first cycle after reset release is a frame start, so mode is captured immediately.
- A TPG_MODE_I change mid-frame takes effect at the next frame start. A change on the frame-start cycle itself is captured.
- DEN_I acts combinationally on the next registered RGB (1-cycle latency) and never affects timing.
- Reset asserted mid-frame returns all state to reset values asynchronously. Counting restarts at 0 after release.

## Configuration
- TPG_MOVING_BAR_EN defined:
  - bar_pos register exists.
  - Mode 11 renders a white BAR_W bar on black, advancing BAR_STEP pixels per frame and wrapping across the right edge.
- TPG_MOVING_BAR_EN undefined:
  - No bar_pos logic.
  - Mode 11 renders black.

## Structure
- Package video_tpg_pkg holds:
  - mode constants (MODE_RED..MODE_BAR)
  - default 640x480 timing constants
  - the eight bar colour constants
- Sub-module video_timing_gen holds the h/v counters, HS/VS/DE generation and the frame-start decode.
- The pattern mux and output registers stay in video_tpg.

## Test plan
- Reset, mode 4, DEN_I=1 -> 800 cycles per line; DE_O high for 640 consecutive cycles; HS_O low for 96 cycles beginning 16 after DE_O falls; 420000 cycles per frame; VS_O low exactly 2 lines.
- Mode 6, line 0 -> R_O/G_O/B_O change every 80 pixels through the 8 listed colours; pixel 80 = FFFF00.
- Switch TPG_MODE_I from 1 to 2 at v_cnt=100 -> remaining frame stays FF0000; the next frame is 00FF00 from its first pixel.
- DEN_I=0 with mode 4 -> RGB=0 on all pixels; HS/VS/DE waveforms identical to the DEN_I=1 case.
- Mode 11 with macro defined -> frame 0 bar at pixels 0..63; frame 1 at 4..67; at bar_pos=600, pixels 600..639 and 0..23 are white. Without the macro -> all black.
- Assert RST_I for 3 cycles mid-line -> outputs go to reset values immediately; FS_O pulses on the first post-release output cycle.
